// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types/constants for the MEM-stage data-memory controller and the decoder.
// No logic; no latency.
// No flow control.
package dmem_access_ctrl_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 255;
    localparam int CTR_W       = 16;

    localparam logic [3:0] OP_LW = 4'h8;
    localparam logic [3:0] OP_SW = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_start(input logic valid, input logic rd, input logic wr);
        return valid & (rd | wr);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Word-wide req/ack data-memory port between the MEM-stage controller and memory.
// Combinational bundle; no latency.
// mem_req is held with stable we/addr/wdata until mem_ack.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_mem_timeout_ctr.sv
// Counts cycles a request has been outstanding; flags the last allowed cycle.
// expired is combinational from the count: high in the TIMEOUT_CYC-th enabled cycle.
// No flow control; clr has priority over en.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CTR_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [CTR_W-1:0] TERM = CTR_W'(TIMEOUT_CYC - 1);

    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CTR_W'(1);
        end
    end

    assign expired = en && (cnt_q == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage LW/SW responder: issues one req/ack memory transaction per load/store and stalls until done.
// Occupancy 3+ cycles: start (stall) -> REQ until ack/timeout (stall) -> DONE (pipeline advances).
// Stalls the pipeline for any memory wait; aborts with sticky error after TIMEOUT_CYC request cycles.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic               stall,
    output logic [DATA_W-1:0]  rdata,
    output logic               rdata_valid,
    output logic               mem_err,
    dmem_access_ctrl_if.master mem
);
    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic ctr_en, ctr_clr, ctr_expired;

    // Counter runs only while requesting and restarts for every transaction.
    assign ctr_en  = (state_q == ST_REQ);
    assign ctr_clr = !ctr_en || mem.mem_ack || ctr_expired;

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CTR_W       (CTR_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        stall       = 1'b0;
        rdata_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (is_start(valid_in, memread, memwrite)) begin
                    stall   = 1'b1;
                    we_d    = memwrite;
                    addr_d  = addr;
                    wdata_d = wdata;
                    // Conflicting strobes resolve to a store but are flagged.
                    if (memread && memwrite) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (ctr_expired) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rdata_valid = !we_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign rdata         = rdata_q;
    assign mem_err       = err_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed table, multi-cycle corner sequences, random transactions vs model.
module tb_dmem_access_ctrl;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, memread, memwrite;
    logic [15:0] addr, wdata, rdata;
    logic        stall, rdata_valid, mem_err;

    dmem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mif ();

    dmem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .memread     (memread),
        .memwrite    (memwrite),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .mem_err     (mem_err),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_arr [logic [15:0]];
    logic [15:0] exp_rdata;
    logic        exp_err;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] wd;
        int          d;
        int          req_cyc;
        logic        rv;
        logic [15:0] rdat;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b0; memread = 1'b0; memwrite = 1'b0;
        addr = '0; wdata = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        chk({nm, "_rdata"}, 32'(rdata), 32'd0);
        chk({nm, "_rv"},    32'(rdata_valid), 32'd0);
        chk({nm, "_req"},   32'(mif.mem_req), 32'd0);
        chk({nm, "_we"},    32'(mif.mem_we), 32'd0);
        chk({nm, "_addr"},  32'(mif.mem_addr), 32'd0);
        chk({nm, "_wdata"}, 32'(mif.mem_wdata), 32'd0);
        chk({nm, "_err"},   32'(mem_err), 32'd0);
    endtask

    // One pipeline cycle with no start: nothing may move.
    task automatic idle_cycle(input logic v, input logic rd, input logic wr, input logic ack);
        @(negedge clk);
        valid_in = v; memread = rd; memwrite = wr;
        mif.mem_ack = ack; mif.mem_rdata = 16'($urandom);
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req",   32'(mif.mem_req), 32'd0);
        chk("idle_rv",    32'(rdata_valid), 32'd0);
    endtask

    // Full transaction; the bench plays memory and acks in request cycle d (0-based).
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input int d, input int req_cyc, input logic rv, input logic [15:0] rdat,
                          input logic err);
        @(negedge clk);
        valid_in = 1'b1; memread = rd; memwrite = wr; addr = a; wdata = wd;
        mif.mem_ack = 1'b0; mif.mem_rdata = 16'($urandom);
        #1;
        chk("start_stall", 32'(stall), 32'd1);
        chk("start_req",   32'(mif.mem_req), 32'd0);
        for (int i = 0; i < req_cyc; i++) begin
            @(negedge clk);
            addr  = 16'($urandom);
            wdata = 16'($urandom);
            if (i == d) begin
                mif.mem_ack = 1'b1; mif.mem_rdata = mem_rd(a);
            end else begin
                mif.mem_ack = 1'b0; mif.mem_rdata = 16'($urandom);
            end
            #1;
            chk("req_req",   32'(mif.mem_req), 32'd1);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_we",    32'(mif.mem_we), 32'(wr));
            chk("req_addr",  32'(mif.mem_addr), 32'(a));
            chk("req_wdata", 32'(mif.mem_wdata), 32'(wd));
            chk("req_rv",    32'(rdata_valid), 32'd0);
            if (i == d && wr) mem_arr[a] = wd;
        end
        @(negedge clk);
        valid_in = 1'b0; memread = 1'($urandom); memwrite = 1'($urandom);
        mif.mem_ack = 1'($urandom); mif.mem_rdata = 16'($urandom);
        #1;
        chk("done_req",   32'(mif.mem_req), 32'd0);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_rv",    32'(rdata_valid), 32'(rv));
        chk("done_rdata", 32'(rdata), 32'(rdat));
        chk("done_err",   32'(mem_err), 32'(err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; memread = 1'b0; memwrite = 1'b0;
        addr = '0; wdata = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        mem_arr[16'h0040] = 16'hBEEF;

        vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 0,  1, 1'b1, 16'hBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 3,  4, 1'b0, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0,  1, 1'b1, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0020, 16'h5678, 0,  1, 1'b0, 16'h1234, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 7,  8, 1'b1, 16'h5678, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 20, 8, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h0050, 16'h9999, 20, 8, 1'b0, 16'h0000, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 2,  3, 1'b1, 16'h5A0A, 1'b1};

        do_reset();
        #1;
        chk_reset_state("reset");

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].d,
                   vecs[i].req_cyc, vecs[i].rv, vecs[i].rdat, vecs[i].err);
        end

        // Reset in the middle of a request, followed by a late ack.
        @(negedge clk);
        valid_in = 1'b1; memread = 1'b1; memwrite = 1'b0; addr = 16'h0060; wdata = 16'h0;
        mif.mem_ack = 1'b0;
        #1 chk("mid_start_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1 chk("mid_req", 32'(mif.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0; memread = 1'b0;
        mif.mem_ack = 1'b1; mif.mem_rdata = 16'hDEAD;
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        mif.mem_ack = 1'b0;
        #1;
        chk_reset_state("late_ack");
        exp_rdata = 16'h0;
        exp_err   = 1'b0;

        // Stray acks and strobes without valid_in.
        repeat (3) idle_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("stray_rdata", 32'(rdata), 32'd0);
        chk("stray_err",   32'(mem_err), 32'd0);
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0, 0, 1, 1'b1, 16'hBEEF, 1'b0);

        // Both strobes: behaves as a store and raises the sticky error.
        do_txn(1'b1, 1'b1, 16'h0070, 16'hABCD, 1, 2, 1'b0, 16'hBEEF, 1'b1);
        do_txn(1'b1, 1'b0, 16'h0070, 16'h0, 0, 1, 1'b1, 16'hABCD, 1'b1);
        exp_rdata = 16'hABCD;
        exp_err   = 1'b1;

        for (int n = 0; n < 40; n++) begin
            int          gap, op, d, req_cyc;
            logic        rd, wr;
            logic [15:0] a, wd;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                idle_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            op = $urandom_range(0, 9);
            rd = (op < 5);
            wr = (op == 0) || (op >= 5);
            a  = {12'h0, 4'($urandom)};
            wd = 16'($urandom);
            d  = $urandom_range(0, 10);
            req_cyc = (d < T) ? d + 1 : T;
            if (!wr) exp_rdata = (d < T) ? mem_rd(a) : 16'h0;
            exp_err = exp_err | (rd & wr) | (d >= T);
            do_txn(rd, wr, a, wd, d, req_cyc, !wr, exp_rdata, exp_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
